multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC loaded on reset and on start.
REQ-002 SHALL have parameter ALU_ADD, default 4'd0, meaning ALU op code for add.
REQ-003 SHALL have parameter ALU_SUB, default 4'd1, meaning ALU op code for subtract.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports start (in 1, pulse: leave IDLE), busy (out 1), halted (out 1), illegal (out 1).
REQ-007 SHALL have memory ports pc (out 32, to Read_PC), instr (in 32), mem_addr (out 32), mem_wdata (out 32), mem_rdata (in 32), mem_en (out 1, to Op2En), mem_rw (out 1, 1=write).
REQ-008 SHALL have register-bank ports reg_we (out 1, to opwrite), reg_wsel (out 2), reg_wdata (out 32), src1 (out 2), src2 (out 2), rdata1 (in 32), rdata2 (in 32).
REQ-009 SHALL have ALU ports alu_a (out 32), alu_b (out 32), alu_op (out 4), alu_result (in 32).

Function
REQ-010 SHALL decode IR as opcode=[31:28], rd=[27:26], rs=[25:24], rt=[23:22], funct=[3:0], imm=[15:0] sign-extended to 32 bits (simm).
REQ-011 SHALL support opcodes: 0 R-type (alu_op=funct), 1 ADDI, 2 LW, 3 SW, 4 BEQ, F HALT; any other opcode is illegal.
REQ-012 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, one cycle each.
REQ-013 IDLE: start=1 -> FETCH, PC<=RESET_PC, halted<=0, illegal<=0; otherwise stay.
REQ-014 FETCH: pc output = PC; at edge IR<=instr, PC<=PC+4 (modulo 2^32) -> DECODE.
REQ-015 DECODE: src1=rs, src2=rt; at edge A<=rdata1, B<=rdata2; HALT/illegal opcode -> HALT (illegal<=1 if illegal), else -> EXEC.
REQ-016 EXEC: alu_a=A; alu_b=B for R-type/BEQ, simm for ADDI/LW/SW; alu_op=funct (R), ALU_SUB (BEQ), ALU_ADD otherwise; at edge ALUOut<=alu_result.
REQ-017 EXEC transitions: R-type/ADDI -> WB; LW/SW -> MEM; BEQ -> FETCH, with PC<=PC+(simm<<2) when alu_result==0, else PC unchanged.
REQ-018 MEM: mem_en=1, mem_addr=ALUOut, mem_rw=1 for SW with mem_wdata=B, mem_rw=0 for LW; LW latches MDR<=mem_rdata and -> WB; SW -> FETCH.
REQ-019 WB: reg_we=1 for exactly one cycle, reg_wsel=rd, reg_wdata=MDR for LW else ALUOut -> FETCH.
REQ-020 Latency: R-type/ADDI 4 cycles, LW 5, SW 4, BEQ 3, HALT 2 (FETCH, DECODE) then HALT.
REQ-021 mem_en, mem_rw, reg_we SHALL be 0 in every state not listed as asserting them; reg_we never asserts in the same cycle as mem_en.
REQ-022 busy=1 in FETCH..WB; halted=1 only in HALT; HALT stays until start=1, which behaves as in IDLE.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 Branch target and PC+4 SHALL wrap modulo 2^32 without error.
REQ-025 Writes to rd of any value (0..3) SHALL be permitted; no register is hardwired.

Reset
REQ-026 rst_n=0 SHALL at once force IDLE, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, busy=halted=illegal=0, all outputs 0.
REQ-027 Reset asserted mid-instruction (including WB or MEM write) SHALL suppress that write in the reset cycle; no write occurs until a new start.
REQ-028 After rst_n rises, block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-029 ADDI r1,r0,5 at addr 0 then HALT at 4 -> reg_we once, reg_wsel=1, reg_wdata=5 (r0=0), halted=1 after 6 cycles from start.
REQ-030 SW r1 -> [r0+8] then LW r2 <- [r0+8] -> mem_rw=1 mem_addr=8 mem_wdata=r1; later reg_wsel=2 reg_wdata=r1; LW takes 5 cycles.
REQ-031 BEQ r1,r1,imm=-1 at addr 12 -> next FETCH pc=12; BEQ with unequal regs -> next pc=16.
REQ-032 Opcode 4'hA fetched -> HALT, illegal=1, no reg_we or mem_en asserted for it.
REQ-033 rst_n pulsed low during WB of ADD -> reg_we=0 immediately, state IDLE, pc=RESET_PC, no write.
REQ-034 start pulsed while busy -> ignored, instruction sequence and cycle counts unchanged.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: sequences FETCH/DECODE/EXEC/MEM/WB for a small
// 4-register ISA, owning PC, IR, A, B, ALUOut and MDR. The register bank,
// ALU and memories are external and reached through the ports below.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [3:0]  ALU_ADD  = 4'd0,
  parameter logic [3:0]  ALU_SUB  = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        reg_we,
  output logic [1:0]  reg_wsel,
  output logic [31:0] reg_wdata,
  output logic [1:0]  src1,
  output logic [1:0]  src2,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'h0,
    OP_ADDI  = 4'h1,
    OP_LW    = 4'h2,
    OP_SW    = 4'h3,
    OP_BEQ   = 4'h4,
    OP_HALT  = 4'hF
  } opcode_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, ir, a_q, b_q, alu_out, mdr;
  logic        illegal_q;

  logic [3:0]  opcode;
  logic [1:0]  rd, rs, rt;
  logic [3:0]  funct;
  logic [31:0] simm;
  logic        is_legal;

  assign opcode   = ir[31:28];
  assign rd       = ir[27:26];
  assign rs       = ir[25:24];
  assign rt       = ir[23:22];
  assign funct    = ir[3:0];
  assign simm     = {{16{ir[15]}}, ir[15:0]};
  assign is_legal = (opcode == OP_RTYPE) || (opcode == OP_ADDI) || (opcode == OP_LW) ||
                    (opcode == OP_SW) || (opcode == OP_BEQ) || (opcode == OP_HALT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Architectural/datapath registers updated at the end of each phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc_q      <= RESET_PC;
            illegal_q <= 1'b0;
          end
        end
        FETCH: begin
          ir   <= instr;
          pc_q <= pc_q + 32'd4;
        end
        DECODE: begin
          a_q <= rdata1;
          b_q <= rdata2;
          if (!is_legal) illegal_q <= 1'b1;
        end
        EXEC: begin
          alu_out <= alu_result;
          // pc_q already holds branch address + 4 here
          if (opcode == OP_BEQ && alu_result == '0)
            pc_q <= pc_q + {simm[29:0], 2'b00};
        end
        MEM: begin
          if (opcode == OP_LW) mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Next-state and per-phase output strobes
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    reg_we    = 1'b0;
    reg_wsel  = '0;
    reg_wdata = '0;
    src1      = '0;
    src2      = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    case (state)
      IDLE, HALT: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: state_nxt = DECODE;
      DECODE: begin
        src1 = rs;
        src2 = rt;
        if (opcode == OP_HALT || !is_legal) state_nxt = HALT;
        else                                state_nxt = EXEC;
      end
      EXEC: begin
        alu_a = a_q;
        if (opcode == OP_RTYPE || opcode == OP_BEQ) alu_b = b_q;
        else                                        alu_b = simm;
        if (opcode == OP_RTYPE)    alu_op = funct;
        else if (opcode == OP_BEQ) alu_op = ALU_SUB;
        else                       alu_op = ALU_ADD;
        if (opcode == OP_RTYPE || opcode == OP_ADDI)   state_nxt = WB;
        else if (opcode == OP_LW || opcode == OP_SW)   state_nxt = MEM;
        else                                           state_nxt = FETCH;
      end
      MEM: begin
        mem_en   = 1'b1;
        mem_addr = alu_out;
        if (opcode == OP_SW) begin
          mem_rw    = 1'b1;
          mem_wdata = b_q;
          state_nxt = FETCH;
        end else begin
          state_nxt = WB;
        end
      end
      WB: begin
        reg_we    = 1'b1;
        reg_wsel  = rd;
        reg_wdata = (opcode == OP_LW) ? mdr : alu_out;
        state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pc      = pc_q;
  assign busy    = state inside {FETCH, DECODE, EXEC, MEM, WB};
  assign halted  = (state == HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: provides register bank, ALU and memories, and
// compares every cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int MAXC = 256;
  localparam logic [31:0] HALT_W = 32'hF000_0000;

  logic        clk, rst_n, start;
  logic        busy, halted, illegal;
  logic [31:0] pc, instr, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_rw, reg_we;
  logic [1:0]  reg_wsel, src1, src2;
  logic [31:0] reg_wdata, rdata1, rdata2, alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;

  multicycle_ctrl #(.RESET_PC(RST_PC), .ALU_ADD(4'd0), .ALU_SUB(4'd1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .halted(halted),
    .illegal(illegal), .pc(pc), .instr(instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_en(mem_en),
    .mem_rw(mem_rw), .reg_we(reg_we), .reg_wsel(reg_wsel),
    .reg_wdata(reg_wdata), .src1(src1), .src2(src2), .rdata1(rdata1),
    .rdata2(rdata2), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment state
  logic [31:0] imem [64];
  logic [31:0] rf [4];
  logic [31:0] dmem [16];
  logic [31:0] seed_rf [4];
  logic [31:0] seed_dm [16];
  logic [31:0] snap_rf [4];
  logic [31:0] snap_dm [16];
  logic        seed_en;

  // Reference model state
  logic [31:0] mreg [4];
  logic [31:0] mdm [16];

  // Expected per-cycle trace
  bit          e_busy [MAXC], e_halt [MAXC], e_ill [MAXC];
  bit          e_we [MAXC], e_men [MAXC], e_mrw [MAXC], e_pcv [MAXC];
  logic [1:0]  e_wsel [MAXC];
  logic [31:0] e_pc [MAXC], e_wdata [MAXC], e_maddr [MAXC], e_mwdata [MAXC];

  int n_total, n_bad;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a ^ ~b;
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [1:0] rt,
                                      input logic [15:0] imm);
    return {op, rd, rs, rt, 6'b0, imm};
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);
  assign instr      = imem[pc[7:2]];
  assign rdata1     = rf[src1];
  assign rdata2     = rf[src2];
  assign mem_rdata  = dmem[mem_addr[5:2]];

  // Register bank and data memory writes (seeded while in reset)
  always @(posedge clk) begin
    if (seed_en) begin
      for (int i = 0; i < 4; i++)  rf[i]   <= seed_rf[i];
      for (int i = 0; i < 16; i++) dmem[i] <= seed_dm[i];
    end else begin
      if (reg_we) rf[reg_wsel] <= reg_wdata;
      if (mem_en && mem_rw) dmem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 64; i++) imem[i] = HALT_W;
  endtask

  task automatic rand_seeds();
    for (int i = 0; i < 4; i++)  seed_rf[i] = $urandom;
    for (int i = 0; i < 16; i++) seed_dm[i] = $urandom;
  endtask

  task automatic rand_prog();
    int k;
    logic [15:0] imm;
    for (int i = 0; i < 64; i++) begin
      k   = $urandom_range(0, 15);
      imm = 16'($urandom);
      if (k <= 2)       imem[i] = enc(4'h0, 2'($urandom), 2'($urandom), 2'($urandom), {12'b0, 4'($urandom)});
      else if (k <= 5)  imem[i] = enc(4'h1, 2'($urandom), 2'($urandom), 2'($urandom), imm);
      else if (k <= 8)  imem[i] = enc(4'h2, 2'($urandom), 2'($urandom), 2'($urandom), imm);
      else if (k <= 11) imem[i] = enc(4'h3, 2'($urandom), 2'($urandom), 2'($urandom), imm);
      else if (k <= 13) imem[i] = enc(4'h4, 2'($urandom), 2'($urandom), 2'($urandom),
                                      16'($urandom_range(0, 8)) - 16'd4);
      else if (k == 14) imem[i] = HALT_W;
      else              imem[i] = enc(4'($urandom_range(5, 14)), 2'($urandom), 2'($urandom), 2'($urandom), imm);
    end
  endtask

  task automatic put_busy(input int t, input int len);
    for (int c = t; c < t + len && c < MAXC; c++) e_busy[c] = 1'b1;
  endtask

  task automatic put_wr(input int c, input logic [1:0] rd, input logic [31:0] v);
    if (c < MAXC) begin
      e_we[c] = 1'b1; e_wsel[c] = rd; e_wdata[c] = v;
    end
    mreg[rd] = v;
  endtask

  task automatic put_mem(input int c, input bit rw, input logic [31:0] a, input logic [31:0] d);
    if (c < MAXC) begin
      e_men[c] = 1'b1; e_mrw[c] = rw; e_maddr[c] = a; e_mwdata[c] = d;
    end
  endtask

  // Instruction-level model: each instruction occupies a fixed number of
  // cycles starting at its fetch; side effects are placed on their cycle.
  task automatic build_trace(input int T);
    logic [31:0] p, w, sx, ad;
    logic [3:0]  op;
    logic [1:0]  rd, rs, rt;
    int          t;
    bit          ill;
    for (int c = 0; c < MAXC; c++) begin
      e_busy[c] = 0; e_halt[c] = 0; e_ill[c] = 0; e_we[c] = 0; e_men[c] = 0;
      e_mrw[c] = 0; e_pcv[c] = 0; e_wsel[c] = '0; e_pc[c] = '0; e_wdata[c] = '0;
      e_maddr[c] = '0; e_mwdata[c] = '0;
    end
    p = RST_PC;
    t = 0;
    while (t < T) begin
      w  = imem[p[7:2]];
      op = w[31:28]; rd = w[27:26]; rs = w[25:24]; rt = w[23:22];
      sx = {{16{w[15]}}, w[15:0]};
      e_pcv[t] = 1'b1; e_pc[t] = p;
      p = p + 32'd4;
      case (op)
        4'h0: begin put_busy(t, 4); put_wr(t + 3, rd, alu_f(w[3:0], mreg[rs], mreg[rt])); t += 4; end
        4'h1: begin put_busy(t, 4); put_wr(t + 3, rd, mreg[rs] + sx); t += 4; end
        4'h2: begin
          ad = mreg[rs] + sx;
          put_busy(t, 5); put_mem(t + 3, 1'b0, ad, 32'h0);
          put_wr(t + 4, rd, mdm[ad[5:2]]);
          t += 5;
        end
        4'h3: begin
          ad = mreg[rs] + sx;
          put_busy(t, 4); put_mem(t + 3, 1'b1, ad, mreg[rt]);
          mdm[ad[5:2]] = mreg[rt];
          t += 4;
        end
        4'h4: begin
          if (mreg[rs] == mreg[rt]) p = p + (sx << 2);
          put_busy(t, 3); t += 3;
        end
        default: begin
          put_busy(t, 2);
          ill = (op != 4'hF);
          for (int c = t + 2; c < T; c++) begin e_halt[c] = 1'b1; e_ill[c] = ill; end
          t = T;
        end
      endcase
    end
  endtask

  task automatic cmp_cycle(input int c);
    check_val($sformatf("busy@%0d", c), busy, e_busy[c]);
    check_val($sformatf("halted@%0d", c), halted, e_halt[c]);
    check_val($sformatf("illegal@%0d", c), illegal, e_ill[c]);
    check_val($sformatf("reg_we@%0d", c), reg_we, e_we[c]);
    if (e_we[c]) begin
      check_val($sformatf("reg_wsel@%0d", c), reg_wsel, e_wsel[c]);
      check_val($sformatf("reg_wdata@%0d", c), reg_wdata, e_wdata[c]);
    end
    check_val($sformatf("mem_en@%0d", c), mem_en, e_men[c]);
    check_val($sformatf("mem_rw@%0d", c), mem_rw, e_mrw[c]);
    if (e_men[c]) begin
      check_val($sformatf("mem_addr@%0d", c), mem_addr, e_maddr[c]);
      if (e_mrw[c]) check_val($sformatf("mem_wdata@%0d", c), mem_wdata, e_mwdata[c]);
    end
    if (e_pcv[c]) check_val($sformatf("fetch_pc@%0d", c), pc, e_pc[c]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; rst_n = 1'b0; seed_en = 1'b1;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_illegal", illegal, 0);
    check_val("rst_pc", pc, RST_PC);
    check_val("rst_strobes", {reg_we, mem_en, mem_rw}, 0);
    check_val("rst_alu", alu_a | alu_b | {28'b0, alu_op}, 0);
    @(negedge clk);
    seed_en = 1'b0; rst_n = 1'b1;
    mreg = seed_rf; mdm = seed_dm;
    repeat (2) begin
      @(negedge clk);
      check_val("idle_hold", {busy, halted}, 0);
    end
  endtask

  // Starts from the current negedge; random start pulses only while busy
  task automatic run_prog(input int T);
    build_trace(T);
    start = 1'b1;
    for (int c = 0; c < T; c++) begin
      @(negedge clk);
      start = 1'b0;
      cmp_cycle(c);
      if (e_busy[c] && $urandom_range(0, 3) == 0) start = 1'b1;
    end
  endtask

  task automatic reset_mid(input int k);
    do_reset();
    start = 1'b1;
    repeat (k + 1) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_val("mid_strobe", {31'b0, reg_we | (mem_en & mem_rw)}, 1);
    snap_rf = rf; snap_dm = dmem;
    rst_n = 1'b0;
    #1;
    check_val("mid_reg_we", reg_we, 0);
    check_val("mid_mem_en", mem_en, 0);
    check_val("mid_busy", busy, 0);
    check_val("mid_pc", pc, RST_PC);
    @(negedge clk);
    for (int i = 0; i < 4; i++)  check_val($sformatf("mid_rf%0d", i), rf[i], snap_rf[i]);
    for (int i = 0; i < 16; i++) check_val($sformatf("mid_dm%0d", i), dmem[i], snap_dm[i]);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("mid_idle", {reg_we, mem_en, busy, halted}, 0);
    end
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; seed_en = 1'b0;
    fill_halt();

    // ADDI r1,r0,5 ; HALT, then restart from HALT
    imem[0] = enc(4'h1, 2'd1, 2'd0, 2'd0, 16'd5);
    rand_seeds(); seed_rf[0] = 32'h0; seed_rf[1] = 32'h0;
    do_reset();
    run_prog(12);
    run_prog(12);

    // SW r1 -> [r0+8] ; LW r2 <- [r0+8] ; HALT
    fill_halt();
    imem[0] = enc(4'h3, 2'd0, 2'd0, 2'd1, 16'd8);
    imem[1] = enc(4'h2, 2'd2, 2'd0, 2'd0, 16'd8);
    rand_seeds(); seed_rf[0] = 32'h0; seed_rf[2] = 32'h0;
    do_reset();
    run_prog(16);

    // BEQ r1,r1,-1 at address 12 loops onto itself
    fill_halt();
    for (int i = 0; i < 3; i++) imem[i] = enc(4'h1, 2'd3, 2'd3, 2'd0, 16'd1);
    imem[3] = enc(4'h4, 2'd0, 2'd1, 2'd1, 16'hFFFF);
    rand_seeds();
    do_reset();
    run_prog(30);

    // BEQ with unequal registers falls through to 16
    imem[3] = enc(4'h4, 2'd0, 2'd1, 2'd2, 16'hFFFF);
    rand_seeds(); seed_rf[2] = seed_rf[1] ^ 32'h1;
    do_reset();
    run_prog(24);

    // Illegal opcode, then restart clears illegal
    fill_halt();
    imem[0] = enc(4'hA, 2'd1, 2'd1, 2'd1, 16'd5);
    rand_seeds();
    do_reset();
    run_prog(8);
    imem[0] = enc(4'h1, 2'd2, 2'd1, 2'd0, 16'h8000);
    run_prog(10);

    // Reset during WB of ADD and during MEM of SW
    fill_halt();
    imem[0] = enc(4'h0, 2'd1, 2'd2, 2'd3, 16'd0);
    rand_seeds(); seed_rf[1] = 32'h0; seed_rf[2] = 32'd5; seed_rf[3] = 32'd7;
    reset_mid(3);
    imem[0] = enc(4'h3, 2'd0, 2'd0, 2'd1, 16'd8);
    rand_seeds(); seed_rf[0] = 32'h0; seed_rf[1] = 32'h0000_CAFE; seed_dm[2] = 32'h0;
    reset_mid(3);

    // Random programs
    repeat (6) begin
      rand_prog();
      rand_seeds();
      do_reset();
      run_prog(160);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
